// File: rtl/memctl_pkg.sv
// Shared types and default sizing for the round-robin memory controller.
package memctl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        NEXT  = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int DEF_N_CORES = 4;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_MEM_LAT = 1;

endpackage

// File: rtl/memctl_rr_pick.sv
// Combinational picker: first set bit of mask at or after start, wrapping
// around; none is raised when the mask is empty.
module memctl_rr_pick
    import memctl_pkg::*;
#(
    parameter int N_CORES = DEF_N_CORES,
    parameter int IDX_W   = $clog2(DEF_N_CORES)
) (
    input  logic [N_CORES-1:0] mask,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   idx,
    output logic               none
);

    // Scan from the farthest position back so the nearest hit wins
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            if (mask[(int'(start) + k) % N_CORES]) begin
                idx  = IDX_W'((int'(start) + k) % N_CORES);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_rr_controller.sv
// Batch memory controller: on a rising MRead or MWrite it services every
// enabled core once, one memory access at a time, in round-robin order.
// Optional feature macro MEMCTL_RR_EN: rotate the starting core between
// batches; without it every batch starts its search at core 0.
module mem_rr_controller
    import memctl_pkg::*;
#(
    parameter int N_CORES = DEF_N_CORES,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             MRead,
    input  logic                             MWrite,
    output logic                             MReady,
    input  logic [N_CORES-1:0]               en,
    input  logic [N_CORES-1:0][ADDR_W-1:0]   in_addr,
    input  logic [N_CORES-1:0][DATA_W-1:0]   in_data,
    output logic [N_CORES-1:0][DATA_W-1:0]   q,
    output logic [N_CORES-1:0]               q_valid,
    output logic [ADDR_W-1:0]                addr_mem,
    output logic [DATA_W-1:0]                data_to_mem,
    output logic                             wren,
    output logic                             rden,
    input  logic [DATA_W-1:0]                data_from_mem
);

    localparam int IDX_W = $clog2(N_CORES);
    localparam int LAT_W = $clog2(MEM_LAT + 1);

    state_t                           state;
    state_t                           state_nxt;
    op_t                              op;
    logic                             prev_rd;
    logic                             prev_wr;
    logic                             rise_rd;
    logic                             rise_wr;
    logic                             launch;
    logic [N_CORES-1:0]               rem;
    logic [N_CORES-1:0][ADDR_W-1:0]   addr_cap;
    logic [N_CORES-1:0][DATA_W-1:0]   data_cap;
    logic [IDX_W-1:0]                 idx;
    logic [IDX_W-1:0]                 rr_ptr;
    logic [N_CORES-1:0]               idx_bit;
    logic [LAT_W-1:0]                 wait_cnt;
    logic                             wait_done;
    logic [N_CORES-1:0]               pick_mask;
    logic [IDX_W-1:0]                 pick_start;
    logic [IDX_W-1:0]                 pick_idx;
    logic                             pick_none;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(N_CORES - 1)) ? '0 : v + IDX_W'(1);
    endfunction

    assign rise_rd   = MRead  & ~prev_rd;
    assign rise_wr   = MWrite & ~prev_wr;
    // A simultaneous read+write rise is ambiguous and dropped; an empty
    // enable mask never leaves IDLE.
    assign launch    = (state == IDLE) && (rise_rd ^ rise_wr) && !pick_none;
    assign idx_bit   = N_CORES'(1) << idx;
    assign wait_done = (wait_cnt == LAT_W'(MEM_LAT - 1));

    // In IDLE the picker looks at the live request; mid-batch it looks at the
    // cores still pending after the current one.
    always_comb begin
        if (state == IDLE) begin
            pick_mask  = en;
            pick_start = rr_ptr;
        end else begin
            pick_mask  = rem & ~idx_bit;
            pick_start = wrap_inc(idx);
        end
    end

    memctl_rr_pick #(
        .N_CORES (N_CORES),
        .IDX_W   (IDX_W)
    ) u_pick (
        .mask  (pick_mask),
        .start (pick_start),
        .idx   (pick_idx),
        .none  (pick_none)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory strobes; strobes live only in ISSUE so they can
    // never overlap and vanish as soon as reset forces IDLE.
    always_comb begin
        state_nxt = state;
        wren      = 1'b0;
        rden      = 1'b0;
        MReady    = (state == IDLE);
        unique case (state)
            IDLE: begin
                if (launch) state_nxt = ISSUE;
            end
            ISSUE: begin
                wren      = (op == OP_WRITE);
                rden      = (op == OP_READ);
                state_nxt = (op == OP_READ) ? WAIT : NEXT;
            end
            WAIT: begin
                if (wait_done) state_nxt = NEXT;
            end
            NEXT: begin
                state_nxt = pick_none ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot of per-core addresses and data taken at batch start
    always_ff @(posedge clk) begin
        if (launch) begin
            addr_cap <= in_addr;
            data_cap <= in_data;
        end
    end

    // Edge history, pending mask, current core, memory bus and read results
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_rd     <= 1'b0;
            prev_wr     <= 1'b0;
            op          <= OP_READ;
            rem         <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
            q           <= '0;
            q_valid     <= '0;
            addr_mem    <= '0;
            data_to_mem <= '0;
        end else begin
            prev_rd <= MRead;
            prev_wr <= MWrite;
            q_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        op          <= rise_rd ? OP_READ : OP_WRITE;
                        rem         <= en;
                        idx         <= pick_idx;
                        addr_mem    <= in_addr[pick_idx];
                        data_to_mem <= in_data[pick_idx];
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + LAT_W'(1);
                    if (wait_done) begin
                        q[idx]       <= data_from_mem;
                        q_valid[idx] <= 1'b1;
                    end
                end
                NEXT: begin
                    rem <= rem & ~idx_bit;
                    if (!pick_none) begin
                        idx         <= pick_idx;
                        addr_mem    <= addr_cap[pick_idx];
                        data_to_mem <= data_cap[pick_idx];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEMCTL_RR_EN
    logic [IDX_W-1:0] first_idx;

    // Remember the batch's first core and rotate the start pointer past it at batch end
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            first_idx <= '0;
        end else if (launch) begin
            first_idx <= pick_idx;
        end else if (state == NEXT && pick_none) begin
            rr_ptr <= wrap_inc(first_idx);
        end
    end
`else
    assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_mem_rr_controller.sv
// Scoreboard bench for mem_rr_controller with a latency-2 memory model.
module tb_mem_rr_controller;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    typedef logic [N-1:0][AW-1:0] addr_vec_t;
    typedef logic [N-1:0][DW-1:0] data_vec_t;

    logic            clk    = 1'b0;
    logic            reset  = 1'b1;
    logic            MRead  = 1'b0;
    logic            MWrite = 1'b0;
    logic            MReady;
    logic [N-1:0]    en      = '0;
    addr_vec_t       in_addr = '0;
    data_vec_t       in_data = '0;
    data_vec_t       q;
    logic [N-1:0]    q_valid;
    logic [AW-1:0]   addr_mem;
    logic [DW-1:0]   data_to_mem;
    logic            wren;
    logic            rden;
    logic [DW-1:0]   data_from_mem;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct {
        int            core;
        logic [DW-1:0] data;
    } qev_t;

    acc_t          exp_acc[$];
    qev_t          exp_q[$];
    logic [DW-1:0] q_model [N] = '{default: '0};
    logic [DW-1:0] mem_pipe [LAT];
    logic          rst_seen  = 1'b1;
    int            checks    = 0;
    int            failures  = 0;
    int            model_ptr = 0;

    always #5 clk = ~clk;

    mem_rr_controller #(
        .N_CORES (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MEM_LAT (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .MRead         (MRead),
        .MWrite        (MWrite),
        .MReady        (MReady),
        .en            (en),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .q             (q),
        .q_valid       (q_valid),
        .addr_mem      (addr_mem),
        .data_to_mem   (data_to_mem),
        .wren          (wren),
        .rden          (rden),
        .data_from_mem (data_from_mem)
    );

    // Memory returns addr+0x100 LAT cycles after a read strobe, garbage otherwise
    always @(posedge clk) begin
        mem_pipe[0] <= rden ? addr_mem + 16'h0100 : 16'hDEAD;
        for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
        rst_seen <= reset;
    end
    assign data_from_mem = mem_pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: which cores a batch serves, in what order, and how long it takes
    task automatic model_batch(input bit rd, input bit wr, input logic [N-1:0] m,
                               input addr_vec_t a, input data_vec_t d,
                               input int limit, output int dur);
        int served = 0;
        int first  = -1;
        dur = 0;
        if (rd == wr) return;
        for (int k = 0; k < N; k++) begin
            int c = (model_ptr + k) % N;
            if (m[c]) begin
                if (first < 0) first = c;
                if (served < limit) begin
                    exp_acc.push_back(acc_t'{wr, a[c], d[c]});
                    if (rd) exp_q.push_back(qev_t'{c, a[c] + 16'h0100});
                end
                served++;
                dur += rd ? 2 + LAT : 2;
            end
        end
`ifdef MEMCTL_RR_EN
        if (first >= 0) model_ptr = (first + 1) % N;
`endif
    endtask

    // Monitor: pops expected accesses and read returns as the DUT presents them
    always @(negedge clk) begin : monitor
        acc_t         a;
        qev_t         e;
        logic [N-1:0] oh;
        if (rst_seen) begin
            for (int i = 0; i < N; i++) q_model[i] = '0;
        end
        check("strobe_overlap", 64'(wren & rden), 0);
        if (wren || rden) begin
            if (exp_acc.size() == 0) begin
                check("unexpected_access", {wren, rden, addr_mem}, 0);
            end else begin
                a = exp_acc.pop_front();
                check("acc_is_write", 64'(wren), 64'(a.wr));
                check("acc_addr", 64'(addr_mem), 64'(a.addr));
                if (a.wr) check("acc_data", 64'(data_to_mem), 64'(a.data));
            end
        end
        if (q_valid != '0) begin
            check("qvalid_onehot", 64'($countones(q_valid)), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_qvalid", 64'(q_valid), 0);
            end else begin
                e = exp_q.pop_front();
                oh = '0;
                oh[e.core] = 1'b1;
                check("qvalid_core", 64'(q_valid), 64'(oh));
                q_model[e.core] = e.data;
            end
        end
        for (int i = 0; i < N; i++) check("q_value", 64'(q[i]), 64'(q_model[i]));
    end

    task automatic launch(input bit rd, input bit wr, input logic [N-1:0] m,
                          input addr_vec_t a, input data_vec_t d);
        @(posedge clk); #1;
        en = m; in_addr = a; in_data = d; MRead = rd; MWrite = wr;
        @(posedge clk); #1;
        MRead = 1'b0; MWrite = 1'b0;
        en = N'($urandom);
        for (int i = 0; i < N; i++) begin
            in_addr[i] = AW'($urandom);
            in_data[i] = DW'($urandom);
        end
    endtask

    task automatic run_batch(input bit rd, input bit wr, input logic [N-1:0] m,
                             input addr_vec_t a, input data_vec_t d, input bit poke);
        int dur;
        int cnt = 0;
        model_batch(rd, wr, m, a, d, N, dur);
        launch(rd, wr, m, a, d);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (MReady) break;
            cnt++;
            if (poke && cnt == 2) MRead = 1'b1;
            if (cnt == 3) MRead = 1'b0;
        end
        MRead = 1'b0;
        check("mready_low_cycles", 64'(cnt), 64'(dur));
        check("queue_drain", 64'(exp_acc.size() + exp_q.size()), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_ptr = 0;
    endtask

    initial begin : stim
        addr_vec_t a;
        data_vec_t d;
        int        dur;
        int        kind;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mready", 64'(MReady), 1);
        check("rst_wren", 64'(wren), 0);
        check("rst_rden", 64'(rden), 0);
        check("rst_qvalid", 64'(q_valid), 0);
        check("rst_q", 64'(q), 0);
        check("rst_addr_mem", 64'(addr_mem), 0);
        check("rst_data_to_mem", 64'(data_to_mem), 0);

        a = {16'h0030, 16'h0020, 16'h0010, 16'h0000};
        d = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        run_batch(1'b0, 1'b1, 4'b1010, a, d, 1'b0);
        run_batch(1'b1, 1'b0, 4'b1111, a, d, 1'b0);
        run_batch(1'b1, 1'b0, 4'b0000, a, d, 1'b0);
        run_batch(1'b1, 1'b1, 4'b1111, a, d, 1'b0);

        do_reset();
        a = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        for (int b = 0; b < 3; b++) run_batch(1'b1, 1'b0, 4'b1111, a, d, 1'b0);

        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = AW'($urandom);
                d[i] = DW'($urandom);
            end
            kind = int'($urandom_range(0, 3));
            run_batch(kind == 0 || kind == 2 || kind == 3, kind == 1 || kind == 2,
                      N'($urandom), a, d, 1'($urandom_range(0, 1)));
        end

        // Reset during the second ISSUE of a write batch
        a = {16'h0a30, 16'h0a20, 16'h0a10, 16'h0a00};
        d = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        model_batch(1'b0, 1'b1, 4'b1111, a, d, 2, dur);
        launch(1'b0, 1'b1, 4'b1111, a, d);
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        check("abort_mready", 64'(MReady), 1);
        check("abort_wren", 64'(wren), 0);
        check("abort_q_zero", 64'(q), 0);
        repeat (6) @(negedge clk);
        check("abort_queue_drain", 64'(exp_acc.size() + exp_q.size()), 0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = AW'($urandom);
                d[i] = DW'($urandom);
            end
            run_batch(t[0], !t[0], N'($urandom_range(1, 15)), a, d, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("final_queue_drain", 64'(exp_acc.size() + exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/mem_rr_controller.md
MEM_RR_CONTROLLER -- requirements
Module: mem_rr_controller

Interface
REQ-001 The block SHALL have parameter N_CORES, default 4, giving the number of core channels (N_CORES >= 2).
REQ-002 The block SHALL have parameter ADDR_W, default 16, giving the memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 16, giving the memory data width.
REQ-004 The block SHALL have parameter MEM_LAT, default 1, giving the read latency of the memory in cycles (MEM_LAT >= 1).
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- MRead  in  1  batch read request.
- MWrite  in  1  batch write request.
- MReady  out  1  high when idle.
- en  in  N_CORES  per-core participation mask.
- in_addr  in  N_CORES x ADDR_W  per-core address.
- in_data  in  N_CORES x DATA_W  per-core write data.
- q  out  N_CORES x DATA_W  per-core read data.
- q_valid  out  N_CORES  one-cycle strobe when q[i] updates.
- addr_mem  out  ADDR_W  memory address.
- data_to_mem  out  DATA_W  memory write data.
- wren  out  1  memory write strobe.
- rden  out  1  memory read strobe.
- data_from_mem  in  DATA_W  memory read data.

Function
REQ-006 A batch SHALL start only in IDLE, on the cycle MRead or MWrite is high after being low in the previous cycle (synchronous rising edge).
REQ-007 If MRead and MWrite both rise in the same cycle, the block SHALL ignore the request, and MReady SHALL stay 1.
REQ-008 On start, the block SHALL capture en, in_addr, in_data and the operation type; later input changes SHALL NOT affect the batch.
REQ-009 If the captured en is all zero, the block SHALL stay in IDLE with MReady=1 and make no memory access.
REQ-010 Otherwise, MReady SHALL go to 0 in the cycle after start and SHALL stay 0 until the batch completes.
REQ-011 The state machine SHALL have four states:
- IDLE -> ISSUE on a valid start.
- ISSUE -> WAIT on a read; ISSUE -> NEXT on a write.
- WAIT -> NEXT after MEM_LAT cycles.
- NEXT -> ISSUE while enabled cores remain; NEXT -> IDLE otherwise.
REQ-012 In ISSUE, for exactly one cycle, the block SHALL drive addr_mem=addr[idx] and, for a write, data_to_mem=data[idx] with wren=1.
REQ-013 In ISSUE, for a read, the block SHALL drive addr_mem=addr[idx] and rden=1 for exactly that cycle.
REQ-014 wren and rden SHALL never both be 1 in the same cycle.
REQ-015 On a read, the block SHALL register q[idx]=data_from_mem MEM_LAT cycles after ISSUE and pulse q_valid[idx] for one cycle; q of other cores SHALL hold its value.
REQ-016 Each enabled core SHALL be serviced exactly once per batch.
REQ-017 Cost per core SHALL be 2 cycles for a write and 2+MEM_LAT cycles for a read.
REQ-018 MReady SHALL return to 1 in the cycle after the last core's NEXT.
REQ-019 Service order SHALL be ascending core index, wrapping from N_CORES-1 to 0, starting at pointer rr_ptr.
REQ-020 MRead or MWrite edges while not in IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-021 On reset, the block SHALL set state=IDLE, MReady=1, wren=0, rden=0, q_valid=0, all q=0, addr_mem=0, data_to_mem=0, rr_ptr=0 and the edge-detect history=0.
REQ-022 Reset asserted mid-batch SHALL abort the batch; wren and rden SHALL be 0 in the cycle after reset is sampled, and the remaining cores SHALL NOT be serviced.

Configuration
REQ-023 When MEMCTL_RR_EN is defined, at batch end rr_ptr SHALL advance to (first core serviced in that batch)+1 modulo N_CORES, rotating priority between batches.
REQ-024 When MEMCTL_RR_EN is not defined, rr_ptr SHALL be constantly 0, giving fixed priority from core 0 upward.

Structure
REQ-025 Package memctl_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, NEXT), the operation enum (OP_READ, OP_WRITE) and the default parameter constants.
REQ-026 Combinational sub-module memctl_rr_pick SHALL return the next set bit of a mask at or after a start index, with wrap-around, plus a none-found flag.

Verification
REQ-027 Reset, then MWrite rise with en=4'b1010, addr={0x30,0x20,0x10,0x00}, data={D,C,B,A} -> wren pulses at addr 0x10 data B, then addr 0x30 data D; MReady is 0 for 4 cycles.
REQ-028 MRead rise with en=4'b1111 and MEM_LAT=2, memory returns addr+0x100 -> q[i]=addr[i]+0x100, four single-cycle q_valid pulses, MReady low for 16 cycles.
REQ-029 MRead with en=0 -> no rden, MReady stays 1; MRead and MWrite rising together -> no access.
REQ-030 With MEMCTL_RR_EN defined, three back-to-back read batches with en=4'b1111 -> first-serviced core is 0, 1, 2; without the macro it is 0 every time.
REQ-031 Reset asserted during the second ISSUE of a write batch -> no further wren, MReady=1 and all q=0 the next cycle; a new batch then runs normally.
